// File: rtl/qam_symbol_packer.sv
// Repacks a framed stream of IN_WIDTH-bit words, MSB first, into SYM_WIDTH-bit
// QAM symbol indices; the last symbol of a frame is zero-padded in its LSBs.
module qam_symbol_packer #(
  parameter int POINTS    = 16,
  parameter int IN_WIDTH  = 8,
  parameter int SYM_WIDTH = $clog2(POINTS),
  parameter int BUF_WIDTH = IN_WIDTH + SYM_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [SYM_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
);

  // One extra bit so that 2*SYM_WIDTH stays representable when SYM_WIDTH == IN_WIDTH.
  localparam int CW = $clog2(BUF_WIDTH + 2);
  localparam logic [CW-1:0] SYM_C     = CW'(SYM_WIDTH);
  localparam logic [CW-1:0] TWO_SYM_C = CW'(2 * SYM_WIDTH);
  localparam logic [CW-1:0] IN_C      = CW'(IN_WIDTH);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valids never look at their own ready, and in_ready alone looks at
  // out_ready, so one slot can be freed and refilled in the same cycle.

  logic [BUF_WIDTH-1:0] bits_q, bits_d, bits_s, in_ext;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_s;
  logic                 flush_q, flush_d;
  logic                 in_fire, out_fire;

  always_comb begin
    in_ready  = !flush_q && ((cnt_q < SYM_C) || ((cnt_q < TWO_SYM_C) && out_ready));
    out_valid = (cnt_q >= SYM_C) || (flush_q && (cnt_q != '0));
    out_last  = flush_q && (cnt_q <= SYM_C) && (cnt_q != '0);
    out_data  = bits_q[BUF_WIDTH-1 -: SYM_WIDTH];
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // Shift out the head symbol first, then append the new word just below the
  // surviving bits; the shift always leaves fewer than SYM_WIDTH bits when a
  // word is appended, so the buffer cannot overflow.
  always_comb begin
    bits_s  = bits_q;
    cnt_s   = cnt_q;
    in_ext  = {in_data, {(BUF_WIDTH - IN_WIDTH){1'b0}}};
    flush_d = flush_q;
    if (out_fire) begin
      bits_s = bits_q << SYM_WIDTH;
      cnt_s  = (cnt_q > SYM_C) ? (cnt_q - SYM_C) : '0;
    end
    bits_d = bits_s;
    cnt_d  = cnt_s;
    if (in_fire) begin
      bits_d = bits_s | (in_ext >> cnt_s);
      cnt_d  = cnt_s + IN_C;
    end
    if (in_fire && in_last) begin
      flush_d = 1'b1;
    end else if (out_fire && out_last) begin
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_qam_symbol_packer.sv
// Bench for qam_symbol_packer: a 16-QAM and a 64-QAM instance fed from bytes,
// checked against constant tables, hand sequences and a bit-queue reference model.
module tb_qam_symbol_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  logic       v16, v64;
  logic       r16, r64;
  logic [3:0] d16;
  logic [5:0] d64;
  logic       ov16, ol16, ov64, ol64;

  always #5 clk = ~clk;

  qam_symbol_packer #(.POINTS(16), .IN_WIDTH(8)) u16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v16), .in_last(in_last),
    .in_ready(r16), .out_data(d16), .out_valid(ov16), .out_last(ol16), .out_ready(out_ready)
  );

  qam_symbol_packer #(.POINTS(64), .IN_WIDTH(8)) u64 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v64), .in_last(in_last),
    .in_ready(r64), .out_data(d64), .out_valid(ov64), .out_last(ol64), .out_ready(out_ready)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  int         sel = 0;
  bit         chk_en = 1'b0;
  bit         rand_rdy = 1'b0;

  logic       mon_ov, mon_ol;
  logic [7:0] mon_d;

  always_comb begin
    mon_ov = (sel == 0) ? ov16 : ov64;
    mon_ol = (sel == 0) ? ol16 : ol64;
    mon_d  = (sel == 0) ? {4'b0, d16} : {2'b0, d64};
  end

  typedef struct {
    int          sel;
    int          nb;
    logic [31:0] bytes;
    int          ns;
    logic [31:0] syms;
  } vec_t;

  vec_t tbl[6];
  bit   exp_rdy[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit   exp_ov[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: every accepted symbol is compared with the expected queue.
  bit         prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;
  always @(negedge clk) begin
    if (!chk_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("valid_held_while_stalled", mon_ov, 1);
        check("data_stable_while_stalled", mon_d, prev_d);
        check("last_stable_while_stalled", mon_ol, prev_l);
      end
      if (mon_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_symbol: got 0x%0h last=%0d, expected no symbol", mon_d, mon_ol);
        end else begin
          check("symbol", {mon_ol, mon_d}, exp_q.pop_front());
        end
      end
      prev_stall = mon_ov && !out_ready;
      prev_d     = mon_d;
      prev_l     = mon_ol;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 99) < 30);
    end
  end

  task automatic send_word(input logic [7:0] d, input logic l);
    bit r;
    bit done = 1'b0;
    in_data = d;
    in_last = l;
    if (sel == 0) v16 = 1'b1;
    else          v64 = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      r = (sel == 0) ? r16 : r64;
      @(posedge clk);
      if (r) done = 1'b1;
    end
    #1;
    v16 = 1'b0;
    v64 = 1'b0;
    in_last = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance within 500 cycles", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_after_frame", mon_ov, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input int s, input logic [7:0] fq[$]);
    bit bq[$];
    logic [7:0] sym;
    for (int i = 0; i < fq.size(); i++)
      for (int b = 7; b >= 0; b--) bq.push_back(fq[i][b]);
    while (bq.size() > 0) begin
      sym = '0;
      for (int k = 0; k < s; k++) begin
        sym = sym << 1;
        if (bq.size() > 0) sym[0] = bq.pop_front();
      end
      exp_q.push_back({(bq.size() == 0), sym});
    end
  endtask

  task automatic random_frames(input int s, input int total);
    logic [7:0] fq[$];
    int rem = total;
    int len;
    while (rem > 0) begin
      len = $urandom_range(1, 8);
      if (len > rem) len = rem;
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(8'($urandom_range(0, 255)));
      model_frame(s, fq);
      for (int i = 0; i < len; i++) send_word(fq[i], (i == len - 1));
      rem -= len;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 2, 32'hA53C0000, 4, 32'h0A05030C};
    tbl[1] = '{1, 3, 32'hFF00C300, 4, 32'h3F300303};
    tbl[2] = '{1, 2, 32'hFF0F0000, 3, 32'h3F303C00};
    tbl[3] = '{0, 1, 32'h12000000, 2, 32'h01020000};
    tbl[4] = '{1, 1, 32'hAB000000, 2, 32'h2A300000};
    tbl[5] = '{1, 1, 32'h81000000, 2, 32'h20100000};

    rst_n = 1'b0; v16 = 1'b0; v64 = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid16", ov16, 0);
    check("rst_out_last16", ol16, 0);
    check("rst_out_data16", d16, 0);
    check("rst_out_valid64", ov64, 0);
    check("rst_out_last64", ol64, 0);
    check("rst_out_data64", d64, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready16", r16, 1);
    check("rst_in_ready64", r64, 1);
    @(posedge clk);
    #1 chk_en = 1'b1;

    // Continuous 16-QAM frame: in_ready alternates, one symbol per cycle.
    sel = 0;
    exp_q.push_back(9'h00A); exp_q.push_back(9'h005);
    exp_q.push_back(9'h003); exp_q.push_back(9'h10C);
    in_data = 8'hA5; in_last = 1'b0; v16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_in_ready", r16, exp_rdy[i]);
      check("t1_out_valid", ov16, exp_ov[i]);
      @(posedge clk);
      #1;
      if (i == 0) begin in_data = 8'h3C; in_last = 1'b1; end
      if (i == 2) begin v16 = 1'b0; in_last = 1'b0; end
    end
    drain();

    for (int t = 0; t < 6; t++) begin
      sel = tbl[t].sel;
      for (int j = 0; j < tbl[t].ns; j++)
        exp_q.push_back({(j == tbl[t].ns - 1), tbl[t].syms[31-8*j -: 8]});
      for (int j = 0; j < tbl[t].nb; j++)
        send_word(tbl[t].bytes[31-8*j -: 8], (j == tbl[t].nb - 1));
      drain();
    end

    // 64-QAM: 8 bits buffered, out_ready low -> next word refused until it rises.
    sel = 1;
    out_ready = 1'b0;
    exp_q.push_back(9'h03F); exp_q.push_back(9'h030); exp_q.push_back(9'h13C);
    send_word(8'hFF, 1'b0);
    in_data = 8'h0F; in_last = 1'b1; v64 = 1'b1;
    @(negedge clk);
    check("refuse_no_room", r64, 0);
    @(negedge clk);
    check("refuse_no_room", r64, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("accept_with_out_ready", r64, 1);
    @(posedge clk);
    #1 v64 = 1'b0; in_last = 1'b0;
    drain();

    // Words offered during a flush are ignored until the frame has drained.
    sel = 0;
    out_ready = 1'b0;
    exp_q.push_back(9'h005); exp_q.push_back(9'h10A);
    exp_q.push_back(9'h00E); exp_q.push_back(9'h10E);
    send_word(8'h5A, 1'b1);
    in_data = 8'hEE; in_last = 1'b1; v16 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_ignore_ready", r16, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_word(8'hEE, 1'b1);
    drain();

    rand_rdy = 1'b1;
    sel = 0;
    random_frames(4, 64);
    drain();
    sel = 1;
    random_frames(6, 48);
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Reset in the middle of a frame with a symbol pending.
    chk_en = 1'b0;
    sel = 0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check("pending_before_reset", ov16, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", ov16, 0);
    check("async_rst_out_last", ol16, 0);
    check("async_rst_out_data", d16, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(9'h001); exp_q.push_back(9'h102);
    send_word(8'h12, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
